div_hilo_ctrl: RTL

//  Sequences the 32-iteration signed divider on behalf of the CPU decode stage: latches operands, pulses
//  the divider start, waits for completion and writes quotient/remainder into the HI/LO registers.

---
 rtl/div_hilo_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl
// Sequences the external 32-iteration signed divider for the decode stage and
// owns the HI/LO register pair. It latches the operands, pulses the divider
// start, waits for completion and writes the remainder to HI and the quotient
// to LO. It also services MTHI/MTLO/MFHI/MFLO, and it stalls the requester
// while a divide is in flight.
//
// Ports
//   clock, reset               rising-edge clock, async active-high reset
//   op_valid, op_code[2:0]     op request (0 NOP, 1 DIV, 2 MTHI, 3 MTLO,
//                              4 MFHI, 5 MFLO, 6-7 NOP)
//   rs_data, rt_data [31:0]    dividend / move source, divisor
//   stall                      op not accepted; requester holds the request
//   rd_data [31:0]             HI or LO for an accepted MFHI/MFLO, else 0
//   hi, lo [31:0]              current HI/LO contents
//   busy                       a divide sequence is in progress
//   err                        sticky divide-timeout flag
//   div_start                  one-cycle start pulse to the divider
//   div_dividend, div_divisor  operands latched for the divider
//   div_busy, div_q, div_r     divider status and results

module div_hilo_ctrl #(
    parameter int          TIMEOUT  = 40,
    parameter logic [31:0] ZERO_VAL = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        err,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_busy,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r
);

    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;

    localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t      state, state_next;
    logic [5:0]  cnt, cnt_next;
    logic        seen_busy, seen_next;
    logic [31:0] hi_next, lo_next;
    logic [31:0] dvd_next, dvs_next;
    logic        err_next;
    logic        accept;
    logic        done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            seen_busy    <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            err          <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            seen_busy    <= seen_next;
            hi           <= hi_next;
            lo           <= lo_next;
            err          <= err_next;
            div_dividend <= dvd_next;
            div_divisor  <= dvs_next;
        end
    end

    // Completion requires having seen div_busy rise first. This way the idle
    // divider's low busy flag in the first WAIT cycle is not taken as done.
    always_comb begin
        accept     = op_valid && (state == S_IDLE);
        done       = seen_busy && !div_busy;
        state_next = state;
        cnt_next   = cnt;
        seen_next  = seen_busy;
        hi_next    = hi;
        lo_next    = lo;
        err_next   = err;
        dvd_next   = div_dividend;
        dvs_next   = div_divisor;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_DIV: begin
                            if (rt_data != 32'd0) begin
                                dvd_next   = rs_data;
                                dvs_next   = rt_data;
                                state_next = S_LAUNCH;
                            end else begin
                                hi_next = rs_data;
                                lo_next = ZERO_VAL;
                            end
                        end
                        OP_MTHI: hi_next = rs_data;
                        OP_MTLO: lo_next = rs_data;
                        default: ;
                    endcase
                end
            end
            S_LAUNCH: begin
                cnt_next   = '0;
                seen_next  = 1'b0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                cnt_next = cnt + 6'd1;
                if (div_busy) begin
                    seen_next = 1'b1;
                end
                if (done) begin
                    hi_next    = div_r;
                    lo_next    = div_q;
                    state_next = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // MFHI/MFLO return the register contents before any update at this edge.
    always_comb begin
        rd_data = '0;
        if (accept && (op_code == OP_MFHI)) begin
            rd_data = hi;
        end else if (accept && (op_code == OP_MFLO)) begin
            rd_data = lo;
        end
    end

    assign stall     = op_valid && (state != S_IDLE);
    assign busy      = (state != S_IDLE);
    assign div_start = (state == S_LAUNCH);

endmodule
